uart_rx_fifo: RTL and testbench

Receive-side buffer that sits directly downstream of uart_rx. It accepts one byte per ff_wr_en pulse from the receiver and presents ff_full back to it. It exposes a read port to the host or consumer logic. It is a synchronous circular buffer with occupancy count, an almost-full flag and sticky overflow detection, so bytes dropped while the consumer stalls are visible.

---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_rx_fifo_ram.sv | 28 ++
 rtl/uart_rx_fifo.sv | 85 ++++++++
 tb/tb_uart_rx_fifo.sv | 127 ++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and helpers for the UART receive path.
package uart_pkg;

  localparam int D_W = 8;

  // Occupancy counter width: must hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_ram.sv
// Simple dual-port storage array (one write, one asynchronous read), kept
// separate so it can later be mapped onto block RAM.
module fifo_ram #(
  parameter int D_W   = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [D_W-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [D_W-1:0] rdata
);

  logic [D_W-1:0] mem [DEPTH];

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  // NOTE: the array has no reset on purpose -- resetting it forbids RAM
  // inference, and validity is tracked by the pointers/count instead.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO downstream of uart_rx with occupancy count, almost-full and
// sticky overflow. Define UART_RX_FIFO_FWFT_EN for first-word-fall-through reads.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int D_W    = uart_pkg::D_W,
  parameter int DEPTH  = 16,
  parameter int AF_LVL = DEPTH - 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ff_wr_en,
  input  logic [D_W-1:0]            wr_data,
  output logic                      ff_full,
  output logic                      ff_afull,
  input  logic                      rd_en,
  output logic [D_W-1:0]            rd_data,
  output logic                      ff_empty,
  output logic [cnt_w(DEPTH)-1:0]   ff_count,
  output logic                      ovf,
  input  logic                      ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count, count_nxt;
  logic [D_W-1:0] ram_rdata;
  logic           wr_acc, rd_acc;

  assign ff_empty = (count == '0);
  assign ff_full  = (count == CW'(DEPTH));
  assign ff_afull = (count >= CW'(AF_LVL));
  assign ff_count = count;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign rd_acc = rd_en & ~ff_empty;
  assign wr_acc = ff_wr_en & (~ff_full | rd_acc);

  fifo_ram #(.D_W(D_W), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (wr_acc & ~rst),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  // NOTE: every combinational output gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      if (ff_wr_en & ff_full & ~rd_acc) ovf <= 1'b1;
      else if (ovf_clr)                 ovf <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_FWFT_EN
  assign rd_data = ram_rdata;
`else
  always_ff @(posedge clk) begin
    if (rst)         rd_data <= '0;
    else if (rd_acc) rd_data <= ram_rdata;
  end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo; handles both default and FWFT builds.
module tb_uart_rx_fifo;

  localparam int DEPTH  = 16;
  localparam int AF_LVL = DEPTH - 2;

  logic       clk = 1'b0;
  logic       rst, ff_wr_en, rd_en, ovf_clr;
  logic [7:0] wr_data, rd_data;
  logic       ff_full, ff_afull, ff_empty, ovf;
  logic [4:0] ff_count;

  uart_rx_fifo #(.D_W(8), .DEPTH(DEPTH), .AF_LVL(AF_LVL)) dut (
    .clk(clk), .rst(rst), .ff_wr_en(ff_wr_en), .wr_data(wr_data),
    .ff_full(ff_full), .ff_afull(ff_afull), .rd_en(rd_en), .rd_data(rd_data),
    .ff_empty(ff_empty), .ff_count(ff_count), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] sb[$];
  int         m_count = 0;
  logic       m_ovf = 1'b0;
  logic [7:0] last_rd = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, ".count"}, 32'(ff_count), 32'(m_count));
    check({tag, ".empty"}, 32'(ff_empty), 32'(m_count == 0));
    check({tag, ".full"},  32'(ff_full),  32'(m_count == DEPTH));
    check({tag, ".afull"}, 32'(ff_afull), 32'(m_count >= AF_LVL));
    check({tag, ".ovf"},   32'(ovf),      32'(m_ovf));
  endtask

  // One clock of stimulus; inputs change 1 ns after an edge, outputs sampled there too.
  task automatic step(input string tag, input logic wr, input logic [7:0] d,
                      input logic rd, input logic clr);
    logic rd_ok, wr_ok;
    logic [7:0] exp_d;
    ff_wr_en = wr; wr_data = d; rd_en = rd; ovf_clr = clr;
    rd_ok = rd && (m_count > 0);
    wr_ok = wr && ((m_count < DEPTH) || rd_ok);
    exp_d = rd_ok ? sb[0] : 8'h00;
`ifdef UART_RX_FIFO_FWFT_EN
    #1;
    if (rd_ok) check({tag, ".head"}, 32'(rd_data), 32'(exp_d));
`endif
    @(posedge clk); #1;
    if (rd_ok) begin
      void'(sb.pop_front());
      m_count--;
      last_rd = exp_d;
    end
    if (wr_ok) begin
      sb.push_back(d);
      m_count++;
    end
    if (wr && (m_count == DEPTH) && !wr_ok) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
`ifndef UART_RX_FIFO_FWFT_EN
    if (rd) check({tag, ".rd_data"}, 32'(rd_data), 32'(last_rd));
`endif
    ff_wr_en = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0;
    check_flags(tag);
  endtask

  task automatic do_reset(input logic wr, input logic rd);
    rst = 1'b1; ff_wr_en = wr; rd_en = rd; wr_data = 8'hEE;
    @(posedge clk); #1;
    rst = 1'b0; ff_wr_en = 1'b0; rd_en = 1'b0;
    sb.delete(); m_count = 0; m_ovf = 1'b0; last_rd = 8'h00;
  endtask

  initial begin
    rst = 1'b1; ff_wr_en = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0; wr_data = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_flags("reset");
`ifndef UART_RX_FIFO_FWFT_EN
    check("reset.rd_data", 32'(rd_data), 32'h0);
`endif

    // Read while empty: nothing moves, rd_data holds.
    step("rd_empty", 1'b0, 8'h00, 1'b1, 1'b0);

    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 8'(i), 1'b0, 1'b0);

    step("ovf_set",   1'b1, 8'hAA, 1'b0, 1'b0);
    step("ovf_clr",   1'b0, 8'h00, 1'b0, 1'b1);
    step("ovf_both",  1'b1, 8'hAB, 1'b0, 1'b1);
    step("ovf_clr2",  1'b0, 8'h00, 1'b0, 1'b1);

    step("full_rw", 1'b1, 8'h55, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0);

    step("empty_rw", 1'b1, 8'h33, 1'b1, 1'b0);
    step("empty_rd", 1'b0, 8'h00, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      step("wrap_wr", 1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
      step("wrap_rd", 1'b0, 8'h00, 1'b1, 1'b0);
      check("wrap.count_le1", 32'(ff_count <= 5'd1), 32'h1);
    end

    for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
    do_reset(1'b1, 1'b1);
    check_flags("mid_rst");
    step("post_rst_wr", 1'b1, 8'h7E, 1'b0, 1'b0);
`ifdef UART_RX_FIFO_FWFT_EN
    check("fwft.show", 32'(rd_data), 32'h7E);
`endif
    step("post_rst_rd", 1'b0, 8'h00, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
